// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0]     DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Force a PC to a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load/bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_pc4,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_pc,
  output logic [PC_W-1:0] o_pc4,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc4;
  logic            r_valid;

  // Register update; bubbles keep the last pc/pc4 so only instr/valid change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= PC_W'(4);
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
        r_pc4   <= i_pc4;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, imem request FSM, hold buffer, pending redirect, IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instrD,
  output logic [PC_W-1:0] pcD,
  output logic [PC_W-1:0] pc4D,
  output logic            validD,
  output logic            fetch_busy
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pcF;
  logic [31:0]     r_hold;
  logic            r_pend_v;
  logic [PC_W-1:0] r_pend_pc;

  logic            w_avail;
  logic            w_redir_acc;
  logic [PC_W-1:0] w_redir_target;
  logic [PC_W-1:0] w_pc4F;
  logic [PC_W-1:0] w_next_pc;
  logic [31:0]     w_word;

  assign w_redir_acc    = redirect_valid && !stallD;
  assign w_redir_target = word_align(redirect_pc);
  assign w_pc4F         = r_pcF + PC_W'(4);
  assign w_word         = (r_state == S_HOLD) ? r_hold : imem_rdata;

  // Fetch completes either from memory (ready, not stalled) or from the hold buffer.
  always_comb begin
    w_avail = 1'b0;
    unique case (r_state)
      S_REQ:   w_avail = imem_ready && !stallF;
      S_HOLD:  w_avail = !stallF;
      default: w_avail = 1'b0;
    endcase
  end

  // Next fetch address: a latched redirect outranks a live one, which outranks pc+4.
  always_comb begin
    w_next_pc = w_pc4F;
    if (r_pend_v)
      w_next_pc = r_pend_pc;
    else if (w_redir_acc)
      w_next_pc = w_redir_target;
  end

  // Request FSM, fetch PC, hold buffer and pending-redirect tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pcF     <= RESET_PC;
      r_hold    <= NOP_INSTR;
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_ready && stallF) begin
            r_hold  <= imem_rdata;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stallF) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase

      // The delay slot is the word at pcF, so a redirect arriving without a
      // completing fetch is parked until that slot has been fetched.
      if (w_avail) begin
        r_pcF <= w_next_pc;
        if (r_pend_v) r_pend_v <= 1'b0;
      end else if (w_redir_acc) begin
        r_pend_v  <= 1'b1;
        r_pend_pc <= w_redir_target;
      end
    end
  end

  assign imem_req   = (r_state == S_REQ);
  assign imem_addr  = r_pcF;
  assign fetch_busy = (r_state == S_REQ) && !imem_ready;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flushD),
    .i_stall (stallD),
    .i_load  (w_avail),
    .i_instr (w_word),
    .i_pc    (r_pcF),
    .i_pc4   (w_pc4F),
    .o_instr (instrD),
    .o_pc    (pcD),
    .o_pc4   (pc4D),
    .o_valid (validD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF, stallD, flushD;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instrD, pcD, pc4D;
  logic        validD, fetch_busy;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  // Memory model: word = C0DE in the top half, address in the bottom half.
  // Returns junk when no request is active so the hold-buffer path is exercised.
  assign imem_rdata = imem_req ? {16'hC0DE, imem_addr[15:0]} : 32'hDEAD_BEEF;

  fetch_stage #(
    .RESET_PC  (32'h0000_3000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stallF         (stallF),
    .stallD         (stallD),
    .flushD         (flushD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instrD         (instrD),
    .pcD            (pcD),
    .pc4D           (pc4D),
    .validD         (validD),
    .fetch_busy     (fetch_busy)
  );

  // A second accepted redirect while one is parked must never be presented.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dut.r_pend_v && redirect_valid && !stallD) begin
      failures++;
      $error("FAIL double_redirect: redirect accepted while pend_v=1");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic v);
    chk({tag, "_pcD"},    pcD,    pc);
    chk({tag, "_pc4D"},   pc4D,   pc + 32'd4);
    chk({tag, "_instrD"}, instrD, ins);
    chk({tag, "_validD"}, {31'b0, validD}, {31'b0, v});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    #1;

    // Reset values
    do_reset();
    rst_n = 1'b0;
    chk("rst_req",   {31'b0, imem_req},   32'd0);
    chk("rst_addr",  imem_addr,           32'h3000);
    chk("rst_busy",  {31'b0, fetch_busy}, 32'd0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // Zero-wait streaming
    tick();
    chk("s1_req",  {31'b0, imem_req}, 32'd1);
    chk("s1_addr", imem_addr,         32'h3000);
    chk("s1_v",    {31'b0, validD},   32'd0);
    tick();
    chk("s1_addr1", imem_addr, 32'h3004);
    chk_ifid("s1a", 32'h3000, 32'hC0DE_3000, 1'b1);

    // Three wait cycles at 0x3004
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      #1;
      chk("w_busy", {31'b0, fetch_busy}, 32'd1);
      chk("w_addr", imem_addr, 32'h3004);
      chk("w_req",  {31'b0, imem_req}, 32'd1);
      tick();
      chk_ifid("w_bub", 32'h3000, 32'h0, 1'b0);
    end
    imem_ready = 1'b1;
    #1;
    chk("w_busy_end", {31'b0, fetch_busy}, 32'd0);
    tick();
    chk_ifid("w_done", 32'h3004, 32'hC0DE_3004, 1'b1);
    chk("w_addr_next", imem_addr, 32'h3008);

    // Stall both stages while 0x3008 is ready -> hold buffer
    stallF = 1'b1; stallD = 1'b1;
    tick();
    chk("h_req0",  {31'b0, imem_req}, 32'd0);
    chk("h_addr0", imem_addr, 32'h3008);
    chk_ifid("h_held0", 32'h3004, 32'hC0DE_3004, 1'b1);
    imem_ready = 1'b0;
    tick();
    chk("h_req1", {31'b0, imem_req}, 32'd0);
    chk_ifid("h_held1", 32'h3004, 32'hC0DE_3004, 1'b1);
    stallF = 1'b0; stallD = 1'b0;
    tick();
    chk_ifid("h_rel", 32'h3008, 32'hC0DE_3008, 1'b1);
    chk("h_addr_next", imem_addr, 32'h300C);
    chk("h_req_next",  {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b1;

    // Zero-wait taken branch at 0x3004; low target bits must be dropped
    do_reset();
    tick(); tick(); tick();
    chk("b_pcD", pcD, 32'h3004);
    chk("b_addr", imem_addr, 32'h3008);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3103;
    tick();
    redirect_valid = 1'b0;
    chk_ifid("b_slot", 32'h3008, 32'hC0DE_3008, 1'b1);
    chk("b_target", imem_addr, 32'h3100);
    tick();
    chk_ifid("b_tgt_id", 32'h3100, 32'hC0DE_3100, 1'b1);
    chk("b_addr_seq", imem_addr, 32'h3104);

    // Same branch while the delay-slot fetch waits two cycles
    do_reset();
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3100; imem_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    chk("p_pend_set", {31'b0, dut.r_pend_v}, 32'd1);
    chk("p_addr_hold0", imem_addr, 32'h3008);
    chk_ifid("p_bub0", 32'h3004, 32'h0, 1'b0);
    tick();
    chk("p_addr_hold1", imem_addr, 32'h3008);
    chk("p_v1", {31'b0, validD}, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk_ifid("p_slot", 32'h3008, 32'hC0DE_3008, 1'b1);
    chk("p_target", imem_addr, 32'h3100);
    chk("p_pend_clr", {31'b0, dut.r_pend_v}, 32'd0);
    tick();
    chk_ifid("p_tgt_id", 32'h3100, 32'hC0DE_3100, 1'b1);
    chk("p_addr_seq", imem_addr, 32'h3104);

    // Flush overrides stall
    flushD = 1'b1; stallD = 1'b1;
    tick();
    flushD = 1'b0; stallD = 1'b0;
    chk_ifid("f_flush", 32'h3100, 32'h0, 1'b0);

    // Reset during an outstanding request
    imem_ready = 1'b0;
    tick();
    chk("r_busy_pre", {31'b0, fetch_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("r_req",  {31'b0, imem_req},   32'd0);
    chk("r_addr", imem_addr,           32'h3000);
    chk("r_busy", {31'b0, fetch_busy}, 32'd0);
    chk_ifid("r_ifid", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    chk("r_restart_req",  {31'b0, imem_req}, 32'd1);
    chk("r_restart_addr", imem_addr, 32'h3000);
    tick();
    chk_ifid("r_restart_id", 32'h3000, 32'hC0DE_3000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
